// File: rtl/test_monitor_pkg.sv
// Shared types and helpers for the test-completion monitor: channel state
// encoding, default register indices and shadow-write decode.
package test_monitor_pkg;

   localparam int REG_IDX_W    = 5;
   localparam int WORD_W       = 32;

   localparam int DEF_DONE_REG = 26;
   localparam int DEF_PASS_REG = 27;
   localparam int DEF_TNUM_REG = 3;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_SETTLE = 3'd1,
      ST_PASS   = 3'd2,
      ST_FAIL   = 3'd3,
      ST_TMO    = 3'd4
   } mon_state_e;

   // True when a write-back targets register idx; x0 writes never count.
   function automatic logic reg_hit(input logic                 we,
                                    input logic [REG_IDX_W-1:0] addr,
                                    input int                   idx);
      return we && (addr != '0) && (addr == REG_IDX_W'(idx));
   endfunction

   function automatic logic is_terminal(input mon_state_e s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
   endfunction

endpackage

// File: rtl/test_monitor_ch.sv
// One monitored write-back channel: done/pass/tnum shadows, settle counter,
// verdict state machine and the test number captured on fail or timeout.
module test_monitor_ch
   import test_monitor_pkg::*;
#(
   parameter int DONE_REG      = DEF_DONE_REG,
   parameter int PASS_REG      = DEF_PASS_REG,
   parameter int TNUM_REG      = DEF_TNUM_REG,
   parameter int SETTLE_CYCLES = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] addr,
   input  logic [WORD_W-1:0]    data,
   input  logic                 timeout_hit,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [WORD_W-1:0]    fail_tnum
);

   // Counter is loaded on SETTLE entry and the verdict is taken when it is 0,
   // so the verdict lands SETTLE_CYCLES edges after entry.
   localparam logic [WORD_W-1:0] SETTLE_LOAD = WORD_W'(SETTLE_CYCLES - 1);

   logic [WORD_W-1:0] done_q;
   logic [WORD_W-1:0] pass_q;
   logic [WORD_W-1:0] tnum_q;
   logic [WORD_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [WORD_W-1:0] fail_tnum_q, fail_tnum_d;
   mon_state_e        state_q, state_d;

   // Shadow copies of the done, pass and test-number registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= '0;
         pass_q <= '0;
         tnum_q <= '0;
      end else begin
         if (reg_hit(we, addr, DONE_REG)) done_q <= data;
         if (reg_hit(we, addr, PASS_REG)) pass_q <= data;
         if (reg_hit(we, addr, TNUM_REG)) tnum_q <= data;
      end
   end

   // Verdict state, settle counter and captured test number.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         settle_cnt_q <= '0;
         fail_tnum_q  <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         fail_tnum_q  <= fail_tnum_d;
      end
   end

   // Next-state logic; a finishing settle window outranks a same-edge timeout.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      fail_tnum_d  = fail_tnum_q;
      unique case (state_q)
         ST_RUN: begin
            if (timeout_hit) begin
               state_d     = ST_TMO;
               fail_tnum_d = tnum_q;
            end else if (done_q == WORD_W'(1)) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == '0) begin
               if (pass_q == WORD_W'(1)) begin
                  state_d = ST_PASS;
               end else begin
                  state_d     = ST_FAIL;
                  fail_tnum_d = tnum_q;
               end
            end else if (timeout_hit) begin
               state_d     = ST_TMO;
               fail_tnum_d = tnum_q;
            end else begin
               settle_cnt_d = settle_cnt_q - WORD_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign done      = is_terminal(state_q);
   assign pass      = (state_q == ST_PASS);
   assign timeout   = (state_q == ST_TMO);
   assign fail_tnum = fail_tnum_q;

endmodule

// File: rtl/test_monitor.sv
// Test-completion monitor: NUM_CH snooped write-back ports, a shared
// saturating cycle counter with timeout detection, and aggregate verdicts.
module test_monitor
   import test_monitor_pkg::*;
#(
   parameter int NUM_CH         = 1,
   parameter int DONE_REG       = DEF_DONE_REG,
   parameter int PASS_REG       = DEF_PASS_REG,
   parameter int TNUM_REG       = DEF_TNUM_REG,
   parameter int SETTLE_CYCLES  = 20,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           wb_we_i,
   input  logic [REG_IDX_W*NUM_CH-1:0] wb_addr_i,
   input  logic [WORD_W*NUM_CH-1:0]    wb_data_i,
   output logic [NUM_CH-1:0]           ch_done_o,
   output logic [NUM_CH-1:0]           ch_pass_o,
   output logic [NUM_CH-1:0]           ch_timeout_o,
   output logic [WORD_W*NUM_CH-1:0]    fail_tnum_o,
   output logic                        all_done_o,
   output logic                        all_pass_o,
   output logic [WORD_W-1:0]           cycles_o
);

   logic [WORD_W-1:0] cycles_q;
   logic              timeout_hit;

   // Cycles since reset release, holding at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycles_q <= '0;
      end else if (cycles_q != '1) begin
         cycles_q <= cycles_q + WORD_W'(1);
      end
   end

   // Timeout fires on the edge where the counter shows TIMEOUT_CYCLES-1.
   if (TIMEOUT_CYCLES != 0) begin : g_tmo
      localparam logic [WORD_W-1:0] TMO_LAST = WORD_W'(TIMEOUT_CYCLES - 1);
      assign timeout_hit = (cycles_q == TMO_LAST);
   end else begin : g_no_tmo
      assign timeout_hit = 1'b0;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      test_monitor_ch #(
         .DONE_REG      (DONE_REG),
         .PASS_REG      (PASS_REG),
         .TNUM_REG      (TNUM_REG),
         .SETTLE_CYCLES (SETTLE_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .we          (wb_we_i[k]),
         .addr        (wb_addr_i[REG_IDX_W*k +: REG_IDX_W]),
         .data        (wb_data_i[WORD_W*k +: WORD_W]),
         .timeout_hit (timeout_hit),
         .done        (ch_done_o[k]),
         .pass        (ch_pass_o[k]),
         .timeout     (ch_timeout_o[k]),
         .fail_tnum   (fail_tnum_o[WORD_W*k +: WORD_W])
      );
   end

   assign all_done_o = &ch_done_o;
   assign all_pass_o = &ch_pass_o;
   assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: directed vector table, a mid-settle reset sequence
// and randomized write-back traffic checked against a deadline-based model.
module tb_test_monitor;

   localparam int NCH    = 3;
   localparam int SETTLE = 20;
   localparam int TMO    = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NCH-1:0]      we;
   logic [5*NCH-1:0]    addr;
   logic [32*NCH-1:0]   data;
   logic [NCH-1:0]      ch_done_o, ch_pass_o, ch_timeout_o;
   logic [32*NCH-1:0]   fail_tnum_o;
   logic                all_done_o, all_pass_o;
   logic [31:0]         cycles_o;

   test_monitor #(
      .NUM_CH(NCH), .DONE_REG(26), .PASS_REG(27), .TNUM_REG(3),
      .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .wb_we_i(we), .wb_addr_i(addr), .wb_data_i(data),
      .ch_done_o(ch_done_o), .ch_pass_o(ch_pass_o), .ch_timeout_o(ch_timeout_o),
      .fail_tnum_o(fail_tnum_o), .all_done_o(all_done_o), .all_pass_o(all_pass_o),
      .cycles_o(cycles_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: verdict 0 none, 1 pass, 2 fail, 3 timeout.
   // A settling channel is described by the cycle count at which it decides.
   int          m_cyc;
   logic [31:0] m_done [NCH];
   logic [31:0] m_pass [NCH];
   logic [31:0] m_tnum [NCH];
   logic [31:0] m_ftn  [NCH];
   int          m_verdict  [NCH];
   int          m_deadline [NCH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_cyc = 0;
         for (int k = 0; k < NCH; k++) begin
            m_done[k] = 0; m_pass[k] = 0; m_tnum[k] = 0; m_ftn[k] = 0;
            m_verdict[k] = 0; m_deadline[k] = -1;
         end
         return;
      end
      for (int k = 0; k < NCH; k++) begin
         if (m_verdict[k] == 0) begin
            if (m_deadline[k] >= 0 && m_deadline[k] == m_cyc) begin
               if (m_pass[k] == 1) m_verdict[k] = 1;
               else begin m_verdict[k] = 2; m_ftn[k] = m_tnum[k]; end
            end else if (m_cyc == TMO - 1) begin
               m_verdict[k] = 3; m_ftn[k] = m_tnum[k];
            end else if (m_deadline[k] < 0 && m_done[k] == 1) begin
               m_deadline[k] = m_cyc + SETTLE;
            end
         end
      end
      for (int k = 0; k < NCH; k++) begin
         logic [4:0]  a;
         logic [31:0] d;
         a = addr[5*k +: 5];
         d = data[32*k +: 32];
         if (we[k] && a != 0) begin
            if (a == 26) m_done[k] = d;
            if (a == 27) m_pass[k] = d;
            if (a == 3)  m_tnum[k] = d;
         end
      end
      m_cyc++;
   endtask

   task automatic compare_model();
      bit ad, ap;
      ad = 1'b1; ap = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         chk($sformatf("ch_done[%0d]", k),    32'(ch_done_o[k]),    32'(m_verdict[k] != 0));
         chk($sformatf("ch_pass[%0d]", k),    32'(ch_pass_o[k]),    32'(m_verdict[k] == 1));
         chk($sformatf("ch_timeout[%0d]", k), 32'(ch_timeout_o[k]), 32'(m_verdict[k] == 3));
         chk($sformatf("fail_tnum[%0d]", k),  fail_tnum_o[32*k +: 32], m_ftn[k]);
         ad = ad & (m_verdict[k] != 0);
         ap = ap & (m_verdict[k] == 1);
      end
      chk("all_done", 32'(all_done_o), 32'(ad));
      chk("all_pass", 32'(all_pass_o), 32'(ap));
      chk("cycles",   cycles_o,        32'(m_cyc));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic clear_inputs();
      we = '0; addr = '0; data = '0;
   endtask

   task automatic drive(input int ch, input bit wr, input int a, input logic [31:0] d);
      clear_inputs();
      we[ch] = wr;
      addr[5*ch +: 5] = 5'(a);
      data[32*ch +: 32] = d;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      bit          rst_first;
      int          ch;
      bit          wr;
      int          a;
      logic [31:0] d;
      int          idle;
      int          cc;
      bit          e_done, e_pass, e_tmo;
      logic [31:0] e_tnum;
      bit          e_all_done, e_all_pass;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst = 1'b1;
      clear_inputs();

      //            rst ch wr  a  d  idle cc dn ps tm tnum ad ap
      // pass path: done written at edge 50, verdict at edge 71
      tbl.push_back('{1, 0, 1, 27, 1, 48, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 26, 1, 20, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0});
      // fail path: done at edge 3, verdict at edge 24
      tbl.push_back('{1, 0, 1,  3, 7,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 27, 0,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 26, 1, 20, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 7, 0, 0});
      // late pass write inside the settle window
      tbl.push_back('{1, 0, 0,  0, 0,  8, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 26, 1, 14, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 27, 1,  5, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0});
      // pass write on the verdict edge itself is too late
      tbl.push_back('{1, 0, 0,  0, 0,  8, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 26, 1, 20, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 27, 1,  0, 0, 1, 0, 0, 0, 0, 0});
      // timeout at edge 100, then a late done changes nothing
      tbl.push_back('{1, 0, 1,  3, 4, 97, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 0, 1, 0, 1, 4, 1, 0});
      tbl.push_back('{0, 0, 1, 26, 1, 25, 0, 1, 0, 1, 4, 1, 0});
      // filtering: x0 write, done value 2, address without enable
      tbl.push_back('{1, 0, 1,  0, 1,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 26, 2,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 26, 1, 30, 0, 0, 0, 0, 0, 0, 0});
      // three channels: ch0 pass, ch1 fail (tnum 9), ch2 pass
      tbl.push_back('{1, 0, 1, 27, 1,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 2, 1, 27, 1,  0, 2, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 1,  3, 9,  0, 1, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 1, 27, 0,  0, 1, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 26, 1,  0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 1, 26, 1,  0, 1, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 2, 1, 26, 1, 18, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 1, 1, 0, 0, 9, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0,  0, 2, 1, 1, 0, 0, 1, 0});

      foreach (tbl[i]) begin
         if (tbl[i].rst_first) do_reset();
         drive(tbl[i].ch, tbl[i].wr, tbl[i].a, tbl[i].d);
         step();
         clear_inputs();
         repeat (tbl[i].idle) step();
         chk($sformatf("vec%0d done", i),  32'(ch_done_o[tbl[i].cc]),    32'(tbl[i].e_done));
         chk($sformatf("vec%0d pass", i),  32'(ch_pass_o[tbl[i].cc]),    32'(tbl[i].e_pass));
         chk($sformatf("vec%0d tmo", i),   32'(ch_timeout_o[tbl[i].cc]), 32'(tbl[i].e_tmo));
         chk($sformatf("vec%0d tnum", i),  fail_tnum_o[32*tbl[i].cc +: 32], tbl[i].e_tnum);
         chk($sformatf("vec%0d all_done", i), 32'(all_done_o), 32'(tbl[i].e_all_done));
         chk($sformatf("vec%0d all_pass", i), 32'(all_pass_o), 32'(tbl[i].e_all_pass));
      end

      // reset in the middle of a settle window clears everything on one edge
      do_reset();
      drive(0, 1'b1, 27, 32'd1); step();
      drive(0, 1'b1, 26, 32'd1); step();
      clear_inputs();
      repeat (5) step();
      rst = 1'b1;
      step();
      chk("midrst ch_done",   32'(ch_done_o),    32'd0);
      chk("midrst ch_pass",   32'(ch_pass_o),    32'd0);
      chk("midrst ch_tmo",    32'(ch_timeout_o), 32'd0);
      chk("midrst all_done",  32'(all_done_o),   32'd0);
      chk("midrst cycles",    cycles_o,          32'd0);
      rst = 1'b0;
      repeat (25) step();
      chk("midrst no rerun verdict", 32'(ch_done_o[0]), 32'd0);
      chk("midrst cycles run", cycles_o, 32'd25);

      // randomized traffic on all channels, long enough to hit timeouts
      for (int ep = 0; ep < 8; ep++) begin
         do_reset();
         for (int c = 0; c < 140; c++) begin
            clear_inputs();
            for (int k = 0; k < NCH; k++) begin
               int r;
               int a;
               logic [31:0] d;
               r = $urandom_range(0, 7);
               case (r)
                  0:       a = 0;
                  1, 7:    a = 3;
                  2, 3:    a = 26;
                  4, 5:    a = 27;
                  default: a = $urandom_range(0, 31);
               endcase
               r = $urandom_range(0, 3);
               case (r)
                  0:       d = 32'd0;
                  1, 2:    d = 32'd1;
                  default: d = $urandom;
               endcase
               we[k] = ($urandom_range(0, 1) == 1);
               addr[5*k +: 5] = 5'(a);
               data[32*k +: 32] = d;
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
